// File: rtl/fx2_pkg.sv
// Shared constants for the FX2 slave-FIFO emulator: endpoint selects and default sizes.
package fx2_pkg;

  // fx2FifoSel_in encodings
  localparam logic OUT_FIFO = 1'b0;  // EP6OUT, host >> FPGA
  localparam logic IN_FIFO  = 1'b1;  // EP8IN,  FPGA >> host

  // Default geometry
  localparam int OUT_DEPTH_DEF = 16;
  localparam int IN_DEPTH_DEF  = 1024;
  localparam int PKT_SIZE_DEF  = 512;

endpackage

// File: rtl/fx2_emu_fifo.sv
// Synchronous first-word-fall-through byte FIFO with an occupancy count.
// The head entry is always visible on rdData_out; pushes while full and pops
// while empty are ignored.
module fx2_emu_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk_in,
  input  logic                     reset_in,
  input  logic [W-1:0]             wrData_in,
  input  logic                     wrEn_in,
  input  logic                     rdEn_in,
  output logic [W-1:0]             rdData_out,
  output logic [$clog2(DEPTH):0]   count_out
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          doPush;
  logic          doPop;

  assign doPush     = wrEn_in & (count != FULL_CNT);
  assign doPop      = rdEn_in & (count != '0);
  assign rdData_out = mem[rdPtr];
  assign count_out  = count;

  // Storage array: written on an accepted push, never reset (pointers define validity).
  always_ff @(posedge clk_in) begin
    if (doPush) mem[wrPtr] <= wrData_in;
  end

  // Pointers wrap naturally modulo DEPTH; count tracks occupancy.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fx2_fifo_emu.sv
// FX2 slave-FIFO emulator. EP6OUT carries host bytes to the FPGA over the shared
// data bus; EP8IN collects FPGA bytes and exposes them to the host only once
// committed, either automatically at PKT_SIZE or early via fx2PktEnd_in.
module fx2_fifo_emu
  import fx2_pkg::*;
#(
  parameter int OUT_DEPTH = OUT_DEPTH_DEF,
  parameter int IN_DEPTH  = IN_DEPTH_DEF,
  parameter int PKT_SIZE  = PKT_SIZE_DEF
) (
  input  logic       fx2Clk_in,
  input  logic       reset_in,
  input  logic       fx2FifoSel_in,
  inout  wire  [7:0] fx2Data_io,
  input  logic       fx2Read_in,
  output logic       fx2GotData_out,
  input  logic       fx2Write_in,
  output logic       fx2GotRoom_out,
  input  logic       fx2PktEnd_in,
  input  logic [7:0] hostWrData_in,
  input  logic       hostWrValid_in,
  output logic       hostWrReady_out,
  output logic [7:0] hostRdData_out,
  output logic       hostRdValid_out,
  input  logic       hostRdReady_in,
  output logic       hostCommit_out
);

  localparam int OCW = $clog2(OUT_DEPTH) + 1;
  localparam int ICW = $clog2(IN_DEPTH) + 1;
  localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_DEPTH);
  localparam logic [ICW-1:0] IN_FULL  = ICW'(IN_DEPTH);
  localparam logic [ICW-1:0] PKT_CNT  = ICW'(PKT_SIZE);

  logic [7:0]     outHead;
  logic [7:0]     inHead;
  logic [OCW-1:0] outCount;
  logic [ICW-1:0] inCount;

  // Handshakes: a transfer happens on a rising edge when its qualifier is true
  // in that cycle (valid&ready on the host side, strobe&flag on the FX2 side).
  logic outPush;
  logic outPop;
  logic inPush;
  logic inPop;

  // EP8IN packet bookkeeping; inCount always equals committed + uncommitted.
  logic [ICW-1:0] committed;
  logic [ICW-1:0] uncommitted;
  logic [ICW-1:0] uncNext;
  logic           pktEndReq;
  logic           commitNow;
  logic           commitPulse;

  assign hostWrReady_out = (outCount != OUT_FULL);
  assign fx2GotData_out  = (outCount != '0);
  assign fx2GotRoom_out  = (inCount != IN_FULL);
  assign hostRdValid_out = (committed != '0);
  assign hostRdData_out  = hostRdValid_out ? inHead : 8'h00;
  assign hostCommit_out  = commitPulse;

  assign outPush = hostWrValid_in & hostWrReady_out;
  assign outPop  = (fx2FifoSel_in == OUT_FIFO) & ~fx2Read_in & fx2GotData_out;
  assign inPush  = (fx2FifoSel_in == IN_FIFO) & ~fx2Write_in & fx2GotRoom_out;
  assign inPop   = hostRdValid_out & hostRdReady_in;

  // The bus is ours only while EP6OUT is selected and we are out of reset.
  assign fx2Data_io = ((fx2FifoSel_in == OUT_FIFO) && !reset_in) ? outHead : 8'hzz;

  // A byte pushed on the same edge as PktEnd belongs to the packet being closed,
  // so both commit triggers look at the post-push uncommitted count. Reaching
  // PKT_SIZE and PktEnd together still yield a single commit.
  assign uncNext   = uncommitted + ICW'(inPush);
  assign pktEndReq = (fx2FifoSel_in == IN_FIFO) & ~fx2PktEnd_in;
  assign commitNow = (uncNext == PKT_CNT) | (pktEndReq & (uncNext != '0));

  fx2_emu_fifo #(
    .DEPTH (OUT_DEPTH),
    .W     (8)
  ) ep6Out (
    .clk_in     (fx2Clk_in),
    .reset_in   (reset_in),
    .wrData_in  (hostWrData_in),
    .wrEn_in    (outPush),
    .rdEn_in    (outPop),
    .rdData_out (outHead),
    .count_out  (outCount)
  );

  fx2_emu_fifo #(
    .DEPTH (IN_DEPTH),
    .W     (8)
  ) ep8In (
    .clk_in     (fx2Clk_in),
    .reset_in   (reset_in),
    .wrData_in  (fx2Data_io),
    .wrEn_in    (inPush),
    .rdEn_in    (inPop),
    .rdData_out (inHead),
    .count_out  (inCount)
  );

  // Committed/uncommitted counters and the one-cycle commit pulse.
  always_ff @(posedge fx2Clk_in or posedge reset_in) begin
    if (reset_in) begin
      committed   <= '0;
      uncommitted <= '0;
      commitPulse <= 1'b0;
    end else begin
      commitPulse <= commitNow;
      if (commitNow) begin
        committed   <= committed - ICW'(inPop) + uncNext;
        uncommitted <= '0;
      end else begin
        committed   <= committed - ICW'(inPop);
        uncommitted <= uncNext;
      end
    end
  end

endmodule

// File: tb/tb_fx2_fifo_emu.sv
// Directed bench for fx2_fifo_emu: driver tasks issue stimulus and push expected
// bytes into per-endpoint queues; a negedge monitor pops and compares whenever
// the DUT transfers a byte out.
module tb_fx2_fifo_emu;

  logic       fx2Clk_in = 1'b0;
  logic       reset_in;
  logic       fx2FifoSel_in;
  wire  [7:0] fx2Data_io;
  logic       fx2Read_in;
  logic       fx2GotData_out;
  logic       fx2Write_in;
  logic       fx2GotRoom_out;
  logic       fx2PktEnd_in;
  logic [7:0] hostWrData_in;
  logic       hostWrValid_in;
  logic       hostWrReady_out;
  logic [7:0] hostRdData_out;
  logic       hostRdValid_out;
  logic       hostRdReady_in;
  logic       hostCommit_out;

  logic [7:0] tbDrv;
  logic       tbDrvEn;

  int checks      = 0;
  int errors      = 0;
  int obs_commits = 0;
  int exp_commits = 0;
  int vcnt;

  logic [7:0] out_exp_q[$];
  logic [7:0] in_exp_q[$];
  logic [7:0] a_bytes[5];

  assign fx2Data_io = tbDrvEn ? tbDrv : 8'hzz;

  fx2_fifo_emu dut (
    .fx2Clk_in       (fx2Clk_in),
    .reset_in        (reset_in),
    .fx2FifoSel_in   (fx2FifoSel_in),
    .fx2Data_io      (fx2Data_io),
    .fx2Read_in      (fx2Read_in),
    .fx2GotData_out  (fx2GotData_out),
    .fx2Write_in     (fx2Write_in),
    .fx2GotRoom_out  (fx2GotRoom_out),
    .fx2PktEnd_in    (fx2PktEnd_in),
    .hostWrData_in   (hostWrData_in),
    .hostWrValid_in  (hostWrValid_in),
    .hostWrReady_out (hostWrReady_out),
    .hostRdData_out  (hostRdData_out),
    .hostRdValid_out (hostRdValid_out),
    .hostRdReady_in  (hostRdReady_in),
    .hostCommit_out  (hostCommit_out)
  );

  // Clock
  always #10 fx2Clk_in = ~fx2Clk_in;

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge fx2Clk_in);
    #1;
  endtask

  task automatic host_push(input logic [7:0] b);
    hostWrData_in  = b;
    hostWrValid_in = 1'b1;
    out_exp_q.push_back(b);
    tick();
    hostWrValid_in = 1'b0;
  endtask

  task automatic fx2_read(input int n);
    fx2FifoSel_in = 1'b0;
    tbDrvEn       = 1'b0;
    fx2Read_in    = 1'b0;
    repeat (n) tick();
    fx2Read_in    = 1'b1;
  endtask

  task automatic fx2_write(input logic [7:0] b, input logic pe, input logic acc);
    fx2FifoSel_in = 1'b1;
    tbDrvEn       = 1'b1;
    tbDrv         = b;
    fx2Write_in   = 1'b0;
    fx2PktEnd_in  = pe;
    if (acc) in_exp_q.push_back(b);
    tick();
    fx2Write_in   = 1'b1;
    fx2PktEnd_in  = 1'b1;
    tbDrvEn       = 1'b0;
  endtask

  task automatic pkt_end();
    fx2FifoSel_in = 1'b1;
    fx2PktEnd_in  = 1'b0;
    tick();
    fx2PktEnd_in  = 1'b1;
  endtask

  task automatic host_read(input int n);
    hostRdReady_in = 1'b1;
    repeat (n) tick();
    hostRdReady_in = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge fx2Clk_in) begin
    if (!reset_in) begin
      if (hostCommit_out) obs_commits++;
      if (fx2FifoSel_in == 1'b0 && !fx2Read_in && fx2GotData_out) begin
        if (out_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ep6out_pop: got byte 0x%0h, required no transfer", fx2Data_io);
        end else begin
          check("ep6out_data", fx2Data_io, out_exp_q.pop_front());
        end
      end
      if (hostRdValid_out && hostRdReady_in) begin
        if (in_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ep8in_pop: got byte 0x%0h, required no transfer", hostRdData_out);
        end else begin
          check("ep8in_data", hostRdData_out, in_exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_in       = 1'b1;
    fx2FifoSel_in  = 1'b0;
    fx2Read_in     = 1'b1;
    fx2Write_in    = 1'b1;
    fx2PktEnd_in   = 1'b1;
    hostWrData_in  = 8'h00;
    hostWrValid_in = 1'b0;
    hostRdReady_in = 1'b0;
    tbDrv          = 8'h00;
    tbDrvEn        = 1'b0;
    a_bytes        = '{8'h81, 8'h00, 8'h00, 8'h00, 8'h03};

    repeat (2) tick();
    check("rst_gotData", fx2GotData_out, 0);
    check("rst_gotRoom", fx2GotRoom_out, 1);
    check("rst_wrReady", hostWrReady_out, 1);
    check("rst_rdValid", hostRdValid_out, 0);
    check("rst_commit", hostCommit_out, 0);
    check("rst_rdData", hostRdData_out, 0);
    tbDrvEn = 1'b1;
    tbDrv   = 8'h00;
    #1;
    check("rst_bus_released", fx2Data_io, 8'h00);
    tbDrvEn = 1'b0;
    reset_in = 1'b0;
    tick();

    // EP6OUT in-order transfer
    for (int i = 0; i < 5; i++) begin
      host_push(a_bytes[i]);
      if (i == 0) check("a_gotData_after_first", fx2GotData_out, 1);
    end
    // With EP8IN selected the DUT must release the bus even though it has data.
    fx2FifoSel_in = 1'b1;
    tbDrvEn       = 1'b1;
    tbDrv         = 8'h00;
    #1;
    check("a_bus_released_sel1", fx2Data_io, 8'h00);
    tbDrvEn = 1'b0;
    fx2_read(5);
    check("a_gotData_after_last", fx2GotData_out, 0);

    // Read strobes while empty are ignored
    fx2_read(2);
    check("e_gotData_empty", fx2GotData_out, 0);
    host_push(8'h6C);
    fx2_read(1);
    check("e_gotData_drained", fx2GotData_out, 0);

    // Simultaneous push and pop on EP6OUT keeps occupancy
    host_push(8'h10);
    for (int k = 1; k <= 4; k++) begin
      hostWrValid_in = 1'b1;
      hostWrData_in  = 8'(8'h10 + k);
      out_exp_q.push_back(8'(8'h10 + k));
      fx2FifoSel_in  = 1'b0;
      fx2Read_in     = 1'b0;
      tick();
    end
    hostWrValid_in = 1'b0;
    fx2Read_in     = 1'b1;
    check("s_gotData_one_left", fx2GotData_out, 1);
    fx2_read(1);
    check("s_gotData_empty", fx2GotData_out, 0);

    // EP6OUT full back-pressure
    for (int i = 0; i < 16; i++) host_push(8'(8'h40 + i));
    check("f_wrReady_full", hostWrReady_out, 0);
    hostWrData_in  = 8'hEE;
    hostWrValid_in = 1'b1;
    tick();
    hostWrValid_in = 1'b0;
    fx2_read(16);
    check("f_gotData_empty", fx2GotData_out, 0);

    // Early commit of a short packet
    fx2_write(8'hA1, 1'b1, 1'b1);
    check("b_rdValid_1", hostRdValid_out, 0);
    fx2_write(8'hA2, 1'b1, 1'b1);
    check("b_rdValid_2", hostRdValid_out, 0);
    fx2_write(8'hA3, 1'b1, 1'b1);
    check("b_rdValid_3", hostRdValid_out, 0);
    pkt_end();
    exp_commits++;
    check("b_commit_pulse", hostCommit_out, 1);
    check("b_rdValid_committed", hostRdValid_out, 1);
    tick();
    check("b_commit_one_cycle", hostCommit_out, 0);
    host_read(3);
    check("b_rdValid_drained", hostRdValid_out, 0);
    check("b_commit_count", obs_commits, exp_commits);

    // Auto-commit at PKT_SIZE
    for (int i = 0; i < 512; i++) begin
      fx2_write(8'(i), 1'b1, 1'b1);
      if (i == 510) check("c_rdValid_before_512", hostRdValid_out, 0);
    end
    exp_commits++;
    check("c_commit_pulse", hostCommit_out, 1);
    vcnt = 0;
    hostRdReady_in = 1'b1;
    for (int i = 0; i < 512; i++) begin
      if (hostRdValid_out) vcnt++;
      tick();
    end
    hostRdReady_in = 1'b0;
    check("c_valid_cycles", vcnt, 512);
    check("c_rdValid_drained", hostRdValid_out, 0);
    check("c_commit_count", obs_commits, exp_commits);

    // Push and PktEnd on the same edge; then PktEnd with nothing pending
    for (int i = 0; i < 4; i++) fx2_write(8'(8'h11 + i), 1'b1, 1'b1);
    check("d_rdValid_pending", hostRdValid_out, 0);
    fx2_write(8'h55, 1'b0, 1'b1);
    exp_commits++;
    check("d_commit_pulse", hostCommit_out, 1);
    tick();
    check("d_commit_one_cycle", hostCommit_out, 0);
    pkt_end();
    check("d_empty_pktend_no_pulse", hostCommit_out, 0);
    host_read(5);
    check("d_rdValid_drained", hostRdValid_out, 0);
    check("d_commit_count", obs_commits, exp_commits);

    // Fill EP8IN; byte 512 also carries PktEnd, which must give a single commit
    for (int i = 0; i < 1024; i++) fx2_write(8'(i * 3), (i == 511) ? 1'b0 : 1'b1, 1'b1);
    exp_commits += 2;
    check("g_gotRoom_full", fx2GotRoom_out, 0);
    fx2_write(8'hEE, 1'b1, 1'b0);
    check("g_gotRoom_still_full", fx2GotRoom_out, 0);
    host_read(1);
    check("g_gotRoom_after_pop", fx2GotRoom_out, 1);
    host_read(1023);
    check("g_rdValid_drained", hostRdValid_out, 0);
    pkt_end();
    check("g_dropped_not_pending", hostCommit_out, 0);
    check("g_commit_count", obs_commits, exp_commits);

    // Reset mid-traffic flushes both endpoints
    for (int i = 0; i < 7; i++) host_push(8'(8'h31 + i));
    for (int i = 0; i < 100; i++) fx2_write(8'(8'h80 + i), 1'b1, 1'b1);
    #4;
    reset_in      = 1'b1;
    fx2FifoSel_in = 1'b0;
    tbDrvEn       = 1'b1;
    tbDrv         = 8'h00;
    #1;
    check("r_gotData", fx2GotData_out, 0);
    check("r_gotRoom", fx2GotRoom_out, 1);
    check("r_wrReady", hostWrReady_out, 1);
    check("r_rdValid", hostRdValid_out, 0);
    check("r_commit", hostCommit_out, 0);
    check("r_rdData", hostRdData_out, 0);
    check("r_bus_released", fx2Data_io, 8'h00);
    out_exp_q.delete();
    in_exp_q.delete();
    tick();
    tick();
    tbDrvEn  = 1'b0;
    reset_in = 1'b0;
    tick();
    check("r_commit_after", hostCommit_out, 0);
    check("r_gotData_after", fx2GotData_out, 0);
    check("r_rdValid_after", hostRdValid_out, 0);
    host_push(8'h99);
    fx2_read(1);
    fx2_write(8'h77, 1'b0, 1'b1);
    exp_commits++;
    host_read(1);
    check("r_rdValid_post", hostRdValid_out, 0);
    tick();

    check("end_out_queue_empty", out_exp_q.size(), 0);
    check("end_in_queue_empty", in_exp_q.size(), 0);
    check("end_commit_count", obs_commits, exp_commits);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx2_fifo_emu.md
FX2_FIFO_EMU -- requirements
Module: fx2_fifo_emu

Interface
REQ-001 The block SHALL have parameter OUT_DEPTH, default 16, meaning EP6OUT (host>>FPGA) FIFO depth in bytes, power of two.
REQ-002 The block SHALL have parameter IN_DEPTH, default 1024, meaning EP8IN (FPGA>>host) FIFO depth in bytes, power of two, >= PKT_SIZE.
REQ-003 The block SHALL have parameter PKT_SIZE, default 512, meaning the EP8IN auto-commit packet size in bytes.
REQ-004 The block SHALL have port fx2Clk_in  in  1  48MHz clock, sole clock.
REQ-005 The block SHALL have port reset_in  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port fx2FifoSel_in  in  1  '0' selects EP6OUT, '1' selects EP8IN.
REQ-007 The block SHALL have port fx2Data_io  inout  8  shared FX2 data bus.
REQ-008 The block SHALL have port fx2Read_in  in  1  active-low pop of EP6OUT.
REQ-009 The block SHALL have port fx2GotData_out  out  1  high when EP6OUT is non-empty.
REQ-010 The block SHALL have port fx2Write_in  in  1  active-low push to EP8IN.
REQ-011 The block SHALL have port fx2GotRoom_out  out  1  high when EP8IN is not full.
REQ-012 The block SHALL have port fx2PktEnd_in  in  1  active-low early commit of EP8IN.
REQ-013 The block SHALL have ports hostWrData_in  in  8, hostWrValid_in  in  1 and hostWrReady_out  out  1, forming the host push stream into EP6OUT.
REQ-014 The block SHALL have ports hostRdData_out  out  8, hostRdValid_out  out  1 and hostRdReady_in  in  1, forming the host pop stream of committed EP8IN bytes.
REQ-015 The block SHALL have port hostCommit_out  out  1  one-cycle pulse per committed EP8IN packet.

Function
REQ-016 EP6OUT SHALL be first-word-fall-through: the head byte is driven on fx2Data_io in the same cycle that fx2GotData_out is high.
REQ-017 The block SHALL drive fx2Data_io only when fx2FifoSel_in=0 and SHALL release it to Z otherwise, whatever the FIFO state.
REQ-018 A host push SHALL occur when hostWrValid_in=1 and hostWrReady_out=1, with hostWrReady_out = EP6OUT not full; fx2GotData_out SHALL rise on the cycle after the first push into an empty FIFO.
REQ-019 An EP6OUT pop SHALL occur on a rising edge with fx2FifoSel_in=0, fx2Read_in=0 and the FIFO non-empty; fx2Read_in=0 while empty SHALL be ignored.
REQ-020 An EP8IN push of fx2Data_io SHALL occur on a rising edge with fx2FifoSel_in=1, fx2Write_in=0 and fx2GotRoom_out=1; a write while full SHALL be dropped.
REQ-021 The block SHALL track committed and uncommitted EP8IN byte counts; only committed bytes are visible to the host, and hostRdValid_out = (committed > 0).
REQ-022 When the uncommitted count reaches PKT_SIZE, the block SHALL commit all uncommitted bytes and pulse hostCommit_out the next cycle.
REQ-023 fx2PktEnd_in=0 with fx2FifoSel_in=1 and uncommitted > 0 SHALL commit all uncommitted bytes and pulse hostCommit_out; with uncommitted = 0 it SHALL be ignored, with no pulse.
REQ-024 When a push and PktEnd occur on the same edge, the pushed byte SHALL be included in the committed packet, with one pulse.
REQ-025 When PKT_SIZE is reached and PktEnd occurs on the same edge, the block SHALL produce exactly one commit.
REQ-026 A host pop SHALL occur when hostRdValid_out=1 and hostRdReady_in=1, with hostRdData_out the FWFT head byte.
REQ-027 Simultaneous push and pop on either FIFO SHALL be legal; occupancy SHALL be unchanged and no byte lost.
REQ-028 Pointers SHALL wrap modulo depth; occupancy counters SHALL be log2(depth)+1 bits wide.

Reset
REQ-029 reset_in SHALL immediately flush both FIFOs, zero all counters, and release fx2Data_io to Z.
REQ-030 While reset_in is asserted, the outputs SHALL be held at fx2GotData_out=0, fx2GotRoom_out=1, hostWrReady_out=1, hostRdValid_out=0, hostCommit_out=0 and hostRdData_out=0.
REQ-031 Reset asserted mid-packet SHALL discard uncommitted and committed bytes, with no commit pulse.

Structure
REQ-032 PKT_SIZE default, OUT_FIFO=0/IN_FIFO=1 and the default depths SHALL reside in the shared package fx2_pkg.
REQ-033 One sub-module, fx2_emu_fifo (parameterised synchronous FWFT FIFO with count output), SHALL be instantiated once for EP6OUT and once for EP8IN.

Verification
REQ-034 Scenario: host pushes 0x81,0x00,0x00,0x00,0x03 -> fx2GotData_out=1 one cycle after the first push; the FPGA reads the bytes in order; fx2GotData_out=0 after the fifth pop.
REQ-035 Scenario: 3 bytes 0xA1,0xA2,0xA3 written to EP8IN, then PktEnd=0 -> hostRdValid_out stays 0 until the commit, hostCommit_out pulses once, and the host reads 0xA1,0xA2,0xA3.
REQ-036 Scenario: 512 consecutive writes of 0x00..0xFF repeated -> one commit at byte 512, no PktEnd needed, and hostRdValid_out stays high for 512 pops.
REQ-037 Scenario: write 0x55 and PktEnd=0 on the same edge with uncommitted=4 -> one commit of 5 bytes; PktEnd=0 with uncommitted=0 -> no pulse.
REQ-038 Scenario: fill EP8IN to IN_DEPTH -> fx2GotRoom_out=0 and a further write is dropped; one host pop -> fx2GotRoom_out=1 the next cycle.
REQ-039 Scenario: assert reset_in with 7 bytes in EP6OUT and 100 uncommitted bytes -> both FIFOs empty, fx2Data_io=Z, no commit pulse.
